cdb_arbiter: RTL and testbench

- Arbitrates the Common Data Bus among all functional units: ALU, MUL, DIV, MEM and JUMP.
- Each unit raises a request with its tagged result. The arbiter picks one winner per cycle and drives a registered cdb_bus_t to every reservation station, the register status table and the requesting units.
- Winner selection is round-robin with starvation aging, so no unit waits longer than a bounded number of cycles.

---
 rtl/cdb_arbiter_pkg.sv | 44 ++++
 rtl/cdb_arbiter_if.sv | 22 ++
 rtl/cdb_arbiter_rr_pick.sv | 30 +++
 rtl/cdb_arbiter.sv | 115 +++++++++++
 tb/tb_cdb_arbiter.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types and constants: functional-unit tags, requester indices, bus structs.
package cdb_arbiter_pkg;

    localparam int NUM_SRBITS  = 8;
    localparam int FU_TAG_W    = 5;
    localparam int CDB_DATA_W  = 32;
    localparam int NUM_CDB_REQ = 5;

    localparam int CDB_REQ_ALU  = 0;
    localparam int CDB_REQ_MUL  = 1;
    localparam int CDB_REQ_DIV  = 2;
    localparam int CDB_REQ_MEM  = 3;
    localparam int CDB_REQ_JUMP = 4;

    localparam logic [FU_TAG_W-1:0] FU_ALU_TAG  = 5'd1;
    localparam logic [FU_TAG_W-1:0] FU_MUL_TAG  = 5'd2;
    localparam logic [FU_TAG_W-1:0] FU_DIV_TAG  = 5'd3;
    localparam logic [FU_TAG_W-1:0] FU_MEM_TAG  = 5'd4;
    localparam logic [FU_TAG_W-1:0] FU_JUMP_TAG = 5'd5;

    typedef struct packed {
        logic [NUM_SRBITS-1:0] tag;
        logic [CDB_DATA_W-1:0] val;
    } tagged_data_t;

    typedef struct packed {
        logic                  valid;
        logic [NUM_SRBITS-1:0] tag;
        logic [CDB_DATA_W-1:0] data;
    } cdb_bus_t;

    // Upper tag bits identifying the unit behind a CDB requester index.
    function automatic logic [FU_TAG_W-1:0] fu_tag(input int unsigned idx);
        case (idx)
            CDB_REQ_ALU:  fu_tag = FU_ALU_TAG;
            CDB_REQ_MUL:  fu_tag = FU_MUL_TAG;
            CDB_REQ_DIV:  fu_tag = FU_DIV_TAG;
            CDB_REQ_MEM:  fu_tag = FU_MEM_TAG;
            CDB_REQ_JUMP: fu_tag = FU_JUMP_TAG;
            default:      fu_tag = '0;
        endcase
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Request/broadcast bundle between the functional units and the CDB arbiter.
interface cdb_arbiter_if
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_CDB_REQ
);
    logic         [NUM_REQ-1:0] req_i;
    tagged_data_t [NUM_REQ-1:0] req_data_i;
    cdb_bus_t                   cdb_o;
    logic         [NUM_REQ-1:0] grant_o;
    logic                       starve_o;

    modport master (
        output req_i, req_data_i,
        input  cdb_o, grant_o, starve_o
    );

    modport slave (
        input  req_i, req_data_i,
        output cdb_o, grant_o, starve_o
    );
endinterface

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set bit of vec at or above ptr, wrapping to 0.
module rr_pick #(
    parameter int N     = 5,
    parameter int PTR_W = 3
) (
    input  logic [N-1:0]     vec,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     onehot,
    output logic             found
);
    logic hit;

    always_comb begin
        onehot = '0;
        hit    = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!hit && vec[i] && (i >= 32'(ptr))) begin
                onehot[i] = 1'b1;
                hit       = 1'b1;
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (!hit && vec[i] && (i < 32'(ptr))) begin
                onehot[i] = 1'b1;
                hit       = 1'b1;
            end
        end
        found = hit;
    end
endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: round-robin among functional units with starvation aging,
// registered broadcast to all consumers.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = NUM_CDB_REQ,
    parameter int MAX_WAIT = 4,
    parameter int TAG_W    = NUM_SRBITS,
    parameter int DATA_W   = CDB_DATA_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    cdb_arbiter_if.slave  bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    logic [NUM_REQ-1:0] last_grant;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] starving;
    logic [NUM_REQ-1:0] age_oh;
    logic [NUM_REQ-1:0] rr_oh;
    logic [NUM_REQ-1:0] win_oh;
    logic               age_found;
    logic               rr_found;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   win_idx;
    logic [CNT_W-1:0]   wait_cnt [NUM_REQ];

    cdb_bus_t           cdb_q;
    logic [NUM_REQ-1:0] grant_q;
    logic               starve_q;

    // A unit granted last edge still holds req while it sees its own tag; keep it out.
    assign last_grant = grant_q;
    assign elig       = bus.req_i & ~last_grant;

    always_comb begin
        starving = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            starving[i] = elig[i] && (wait_cnt[i] == CNT_W'(MAX_WAIT));
        end
    end

    // Aging reuses the picker with pointer 0 so the lowest starving index wins.
    rr_pick #(.N(NUM_REQ), .PTR_W(PTR_W)) u_age_pick (
        .vec    (starving),
        .ptr    ('0),
        .onehot (age_oh),
        .found  (age_found)
    );

    rr_pick #(.N(NUM_REQ), .PTR_W(PTR_W)) u_rr_pick (
        .vec    (elig),
        .ptr    (rr_ptr),
        .onehot (rr_oh),
        .found  (rr_found)
    );

    always_comb begin
        win_oh  = age_found ? age_oh : rr_oh;
        win_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_oh[i]) win_idx = PTR_W'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_q    <= '0;
            grant_q  <= '0;
            starve_q <= 1'b0;
            rr_ptr   <= '0;
        end else if (flush) begin
            cdb_q    <= '0;
            grant_q  <= '0;
            starve_q <= 1'b0;
        end else if (rr_found) begin
            cdb_q.valid <= 1'b1;
            cdb_q.tag   <= TAG_W'(bus.req_data_i[win_idx].tag);
            cdb_q.data  <= DATA_W'(bus.req_data_i[win_idx].val);
            grant_q     <= win_oh;
            starve_q    <= age_found;
            rr_ptr      <= (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        end else begin
            cdb_q    <= '0;
            grant_q  <= '0;
            starve_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) wait_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (flush || win_oh[i] || !bus.req_i[i]) begin
                    wait_cnt[i] <= '0;
                end else if (elig[i] && (wait_cnt[i] != CNT_W'(MAX_WAIT))) begin
                    wait_cnt[i] <= wait_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign bus.cdb_o    = cdb_q;
    assign bus.grant_o  = grant_q;
    assign bus.starve_o = starve_q;

    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_q));
    a_valid_grant:  assert property (@(posedge clk) disable iff (!rst_n) cdb_q.valid == (|grant_q));
    a_no_repeat:    assert property (@(posedge clk) disable iff (!rst_n) (grant_q & $past(grant_q)) == '0);

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed scenarios followed by randomized requesters.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int NREQ = NUM_CDB_REQ;
    localparam int MAXW = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    cdb_arbiter_if #(.NUM_REQ(NREQ)) bus ();

    cdb_arbiter #(
        .NUM_REQ  (NREQ),
        .MAX_WAIT (MAXW),
        .TAG_W    (NUM_SRBITS),
        .DATA_W   (CDB_DATA_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                    cyc;
        logic [NUM_SRBITS-1:0] tag;
        logic [CDB_DATA_W-1:0] data;
        logic [NREQ-1:0]       grant;
        logic                  starve;
    } exp_t;

    exp_t     exp_q[$];
    exp_t     mon_e;
    int       vectors     = 0;
    int       miscompares = 0;
    int       edge_n      = 0;
    int       starve4     = 0;
    int       m_wait[NREQ];
    int       m_ptr;
    int       m_last;
    int       rr_cnt[NREQ];
    logic [2:0] seq[NREQ];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", name, edge_n, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_ptr  = 0;
        m_last = -1;
        for (int i = 0; i < NREQ; i++) m_wait[i] = 0;
    endfunction

    // Reference arbitration decision for one clock edge, from the current inputs.
    task automatic model_edge();
        exp_t e;
        int   w;
        bit   st;
        bit   el[NREQ];
        if (flush) begin
            for (int i = 0; i < NREQ; i++) m_wait[i] = 0;
            m_last = -1;
            return;
        end
        w  = -1;
        st = 1'b0;
        for (int i = 0; i < NREQ; i++) el[i] = bus.req_i[i] && (i != m_last);
        for (int i = 0; i < NREQ; i++) begin
            if (w < 0 && el[i] && m_wait[i] == MAXW) begin
                w  = i;
                st = 1'b1;
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (m_ptr + k) % NREQ;
            if (w < 0 && el[j]) w = j;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (i == w || !bus.req_i[i]) m_wait[i] = 0;
            else if (el[i] && m_wait[i] < MAXW) m_wait[i]++;
        end
        if (w >= 0) begin
            e.cyc    = edge_n;
            e.tag    = bus.req_data_i[w].tag;
            e.data   = bus.req_data_i[w].val;
            e.grant  = NREQ'(1) << w;
            e.starve = st;
            exp_q.push_back(e);
            m_ptr  = (w + 1) % NREQ;
            m_last = w;
        end else begin
            m_last = -1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        edge_n++;
        model_edge();
        #1;
    endtask

    task automatic new_tag(input int i);
        seq[i] = seq[i] + 3'd1;
        bus.req_data_i[i].tag = {fu_tag(i), seq[i]};
        bus.req_data_i[i].val = $urandom;
    endtask

    task automatic raise(input int i);
        new_tag(i);
        bus.req_i[i] = 1'b1;
    endtask

    // Requester behaviour after an edge: 0 random, 1 drop then re-raise 2 later,
    // 2 re-raise immediately with a new tag, 3 drop and stay idle.
    task automatic drive(input int mode);
        for (int i = 0; i < NREQ; i++) begin
            if (m_last == i) begin
                case (mode)
                    0: if ($urandom_range(0, 1) == 0) bus.req_i[i] = 1'b0; else new_tag(i);
                    1: begin bus.req_i[i] = 1'b0; rr_cnt[i] = 2; end
                    2: new_tag(i);
                    default: bus.req_i[i] = 1'b0;
                endcase
            end else if (mode == 1 && rr_cnt[i] > 0) begin
                rr_cnt[i]--;
                if (rr_cnt[i] == 0) raise(i);
            end else if (mode == 0 && !bus.req_i[i] && $urandom_range(0, 2) == 0) begin
                raise(i);
            end
        end
        flush = (mode == 0) && ($urandom_range(0, 19) == 0);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        flush     = 1'b0;
        bus.req_i = '0;
        exp_q.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == edge_n) begin
                mon_e = exp_q.pop_front();
                chk("cdb_valid",  64'(bus.cdb_o.valid), 64'(1'b1));
                chk("cdb_tag",    64'(bus.cdb_o.tag),   64'(mon_e.tag));
                chk("cdb_data",   64'(bus.cdb_o.data),  64'(mon_e.data));
                chk("grant",      64'(bus.grant_o),     64'(mon_e.grant));
                chk("starve",     64'(bus.starve_o),    64'(mon_e.starve));
            end else begin
                chk("idle_valid",  64'(bus.cdb_o.valid), 64'(0));
                chk("idle_grant",  64'(bus.grant_o),     64'(0));
                chk("idle_starve", 64'(bus.starve_o),    64'(0));
            end
            if (exp_q.size() > 0 && exp_q[0].cyc < edge_n) begin
                vectors++;
                miscompares++;
                $display("FAIL missed_grant @edge %0d: got none expected grant from edge %0d", edge_n, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (bus.cdb_o.valid && bus.grant_o[CDB_REQ_JUMP] && bus.starve_o) starve4++;
        end
    end

    initial begin
        rst_n          = 1'b0;
        flush          = 1'b0;
        bus.req_i      = '0;
        bus.req_data_i = '0;
        for (int i = 0; i < NREQ; i++) begin
            seq[i]    = '0;
            rr_cnt[i] = 0;
        end
        do_reset();

        // reset / idle
        repeat (10) step();

        // single requester, held one cycle past its grant
        bus.req_data_i[CDB_REQ_ALU].tag = 8'h0C;
        bus.req_data_i[CDB_REQ_ALU].val = 32'h1234;
        bus.req_i = 5'b00001;
        step();
        step();
        bus.req_i[CDB_REQ_ALU] = 1'b0;
        repeat (3) step();

        // round-robin rotation from pointer 0
        do_reset();
        for (int i = 0; i < NREQ; i++) raise(i);
        repeat (16) begin step(); drive(1); end
        bus.req_i = '0;
        for (int i = 0; i < NREQ; i++) rr_cnt[i] = 0;
        repeat (2) step();

        // aging: JUMP must be forced through by the starvation override
        do_reset();
        starve4 = 0;
        raise(CDB_REQ_ALU);
        raise(CDB_REQ_MUL);
        raise(CDB_REQ_JUMP);
        repeat (12) begin step(); drive(2); end
        bus.req_i = '0;
        repeat (2) step();
        chk("aging_jump_starved", 64'(starve4 > 0), 64'(1));

        // flush on the arbitration edge
        raise(CDB_REQ_MUL);
        raise(CDB_REQ_DIV);
        raise(CDB_REQ_MEM);
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (6) begin step(); drive(3); end

        // asynchronous reset during a broadcast
        bus.req_i = '0;
        step();
        raise(CDB_REQ_DIV);
        step();
        #2;
        chk("pre_rst_valid", 64'(bus.cdb_o.valid), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(bus.cdb_o.valid), 64'(0));
        chk("async_rst_grant", 64'(bus.grant_o),     64'(0));
        do_reset();
        raise(CDB_REQ_MUL);
        raise(CDB_REQ_MEM);
        repeat (5) begin step(); drive(3); end

        // randomized requesters with occasional flush
        repeat (3000) begin step(); drive(0); end
        bus.req_i = '0;
        flush     = 1'b0;
        repeat (3) step();
        chk("queue_empty", 64'(exp_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
